memory_stage: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline, sitting between the execute stage's XM_* pipeline register and writeback. It consumes the execute-stage result, address, and flags. For lw/sw it runs a req/ack transaction on the data-memory port and stalls upstream until that transaction completes. It registers the MW_* writeback bundle.

---
 rtl/memory_stage.sv | 159 +++++++++++++++
 tb/tb_memory_stage.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// MIPS MEM stage: ALU results pass through; lw/sw run a req/ack data-memory access. Optional abort via MEM_TIMEOUT_EN.
// Latency: 1 cycle for non-memory ops; 2 cycles plus 1 per extra no-ack cycle for lw/sw.
// Backpressure: stall is high throughout WAIT, so upstream holds XM_* until the access finishes.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_valid,
    input  logic [31:0] XM_ALUout,
    input  logic [31:0] XM_B,
    input  logic [4:0]  XM_RD,
    input  logic        XM_lwFlag,
    input  logic        XM_swFlag,
    input  logic [2:0]  XM_compareFlag,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        MW_valid,
    output logic        MW_wen,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_data,
    output logic        mem_err
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [4:0]  pend_rd, pend_rd_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic        MW_valid_nxt, MW_wen_nxt;
    logic [4:0]  MW_RD_nxt;
    logic [31:0] MW_data_nxt;
    logic        is_mem_op;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memory_stage: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt, to_cnt_nxt;
    logic       mem_err_nxt;
`endif

    assign is_mem_op = XM_lwFlag | XM_swFlag;
    // Pure decode of the state flop, so stall never has a combinational input path.
    assign stall     = (state == WAIT);

    always_comb begin
        state_nxt     = state;
        pend_rd_nxt   = pend_rd;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        MW_valid_nxt  = 1'b0;
        MW_wen_nxt    = 1'b0;
        MW_RD_nxt     = MW_RD;
        MW_data_nxt   = MW_data;
`ifdef MEM_TIMEOUT_EN
        to_cnt_nxt    = to_cnt;
        mem_err_nxt   = mem_err;
`endif
        case (state)
            IDLE: begin
                if (XM_valid) begin
                    if (is_mem_op) begin
                        mem_addr_nxt  = {XM_ALUout[31:2], 2'b00};
                        mem_wdata_nxt = XM_B;
                        mem_we_nxt    = XM_swFlag;
                        pend_rd_nxt   = XM_RD;
                        mem_req_nxt   = 1'b1;
                        state_nxt     = WAIT;
`ifdef MEM_TIMEOUT_EN
                        to_cnt_nxt    = 8'd0;
`endif
                    end else begin
                        MW_valid_nxt = 1'b1;
                        MW_RD_nxt    = XM_RD;
                        MW_data_nxt  = XM_ALUout;
                        MW_wen_nxt   = (XM_RD != 5'd0) && (XM_compareFlag != 3'd1);
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_nxt  = 1'b0;
                    state_nxt    = IDLE;
                    MW_valid_nxt = 1'b1;
                    MW_RD_nxt    = pend_rd;
                    if (mem_we) begin
                        MW_data_nxt = mem_addr;
                    end else begin
                        MW_data_nxt = mem_rdata;
                        MW_wen_nxt  = (pend_rd != 5'd0);
                    end
                end
`ifdef MEM_TIMEOUT_EN
                // Ack is tested first, so an ack on the timeout edge still completes normally.
                else if (to_cnt == TIMEOUT_LAST) begin
                    mem_req_nxt  = 1'b0;
                    state_nxt    = IDLE;
                    MW_valid_nxt = 1'b1;
                    MW_RD_nxt    = pend_rd;
                    mem_err_nxt  = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 8'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_rd   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            MW_valid  <= 1'b0;
            MW_wen    <= 1'b0;
            MW_RD     <= '0;
            MW_data   <= '0;
        end else begin
            state     <= state_nxt;
            pend_rd   <= pend_rd_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            MW_valid  <= MW_valid_nxt;
            MW_wen    <= MW_wen_nxt;
            MW_RD     <= MW_RD_nxt;
            MW_data   <= MW_data_nxt;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            to_cnt  <= to_cnt_nxt;
            mem_err <= mem_err_nxt;
        end
    end
`else
    assign mem_err = 1'b0;
`endif
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_memory_stage;
    logic        clk, rst, XM_valid;
    logic [31:0] XM_ALUout, XM_B;
    logic [4:0]  XM_RD;
    logic        XM_lwFlag, XM_swFlag;
    logic [2:0]  XM_compareFlag;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        MW_valid, MW_wen;
    logic [4:0]  MW_RD;
    logic [31:0] MW_data;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    // Memory responder controls: ack after ack_lat cycles of mem_req.
    logic        resp_en = 1'b0;
    int          ack_lat = 1;
    logic        rdata_rand = 1'b0;
    logic [31:0] rdata_cfg = 32'd0;
    int          wait_cnt = 0;
    logic [31:0] rdata_q[$];

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        is_mem;
        logic        is_lw;
    } wb_t;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;
    wb_t   wb_q[$];
    mreq_t mreq_q[$];
    logic  drv_done;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .XM_valid(XM_valid), .XM_ALUout(XM_ALUout), .XM_B(XM_B),
        .XM_RD(XM_RD), .XM_lwFlag(XM_lwFlag), .XM_swFlag(XM_swFlag),
        .XM_compareFlag(XM_compareFlag), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MW_valid(MW_valid), .MW_wen(MW_wen), .MW_RD(MW_RD), .MW_data(MW_data), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (resp_en && mem_req && !rst) begin
                if (wait_cnt >= ack_lat - 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_rand ? $urandom : rdata_cfg;
                    rdata_q.push_back(mem_rdata);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic drive(input logic v, input logic lw, input logic sw, input logic [2:0] cmp,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] b);
        XM_valid = v; XM_lwFlag = lw; XM_swFlag = sw; XM_compareFlag = cmp;
        XM_RD = rd; XM_ALUout = alu; XM_B = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({stall, mem_req, mem_we, mem_addr, mem_wdata, MW_valid, MW_wen, MW_RD, MW_data, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: stall=%b req=%b we=%b addr=%h wdata=%h MWv=%b wen=%b rd=%0d data=%h err=%b, required all zero",
                     stall, mem_req, mem_we, mem_addr, mem_wdata, MW_valid, MW_wen, MW_RD, MW_data, mem_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu;
        @(posedge clk); #1 drive(1, 0, 0, 3'd2, 5'd5, 32'h7, 32'h0);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall_pre: stall=%b required 0", stall);
        end
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({MW_valid, MW_wen, MW_RD, MW_data, stall} !== {1'b1, 1'b1, 5'd5, 32'd7, 1'b0}) begin
            errors++;
            $display("FAIL alu_wb: valid=%b wen=%b rd=%0d data=%h stall=%b, required 1 1 5 00000007 0",
                     MW_valid, MW_wen, MW_RD, MW_data, stall);
        end
        @(negedge clk);
        checks++;
        if ({MW_valid, MW_wen, MW_RD, MW_data} !== {1'b0, 1'b0, 5'd5, 32'd7}) begin
            errors++;
            $display("FAIL alu_idle_hold: valid=%b wen=%b rd=%0d data=%h, required 0 0 5 00000007",
                     MW_valid, MW_wen, MW_RD, MW_data);
        end
    endtask

    task automatic test_compare;
        logic [2:0]  cmp_t[3] = '{3'd1, 3'd2, 3'd0};
        logic [4:0]  rd_t[3]  = '{5'd3, 5'd0, 5'd4};
        logic [31:0] alu_t[3] = '{32'h40, 32'h1234, 32'h1};
        logic        wen_t[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 drive(1, 0, 0, cmp_t[i], rd_t[i], alu_t[i], 32'h0);
            @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
            @(negedge clk);
            checks++;
            if ({MW_valid, MW_wen, MW_RD, MW_data} !== {1'b1, wen_t[i], rd_t[i], alu_t[i]}) begin
                errors++;
                $display("FAIL compare_wen[%0d]: valid=%b wen=%b rd=%0d data=%h, required 1 %b %0d %h",
                         i, MW_valid, MW_wen, MW_RD, MW_data, wen_t[i], rd_t[i], alu_t[i]);
            end
        end
    endtask

    task automatic test_lw_wait;
        resp_en = 1'b1; ack_lat = 3; rdata_rand = 1'b0; rdata_cfg = 32'hDEADBEEF;
        @(posedge clk); #1 drive(1, 1, 0, 3'd2, 5'd8, 32'h103, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, stall, mem_we, mem_addr, MW_valid} !== {1'b1, 1'b1, 1'b0, 32'h100, 1'b0}) begin
                errors++;
                $display("FAIL lw_wait[%0d]: req=%b stall=%b we=%b addr=%h MWv=%b, required 1 1 0 00000100 0",
                         i, mem_req, stall, mem_we, mem_addr, MW_valid);
            end
        end
        @(negedge clk);
        checks++;
        if ({mem_req, stall, MW_valid, MW_wen, MW_RD, MW_data} !== {1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL lw_wb: req=%b stall=%b valid=%b wen=%b rd=%0d data=%h, required 0 0 1 1 8 deadbeef",
                     mem_req, stall, MW_valid, MW_wen, MW_RD, MW_data);
        end
    endtask

    task automatic test_back_to_back;
        resp_en = 1'b1; ack_lat = 1;
        @(posedge clk); #1 drive(1, 0, 1, 3'd2, 5'd9, 32'h20, 32'h1234);
        @(posedge clk); #1 drive(1, 0, 0, 3'd2, 5'd6, 32'h55, 32'h0);
        @(negedge clk);
        checks++;
        if ({mem_req, stall, mem_we, mem_wdata, mem_addr} !== {1'b1, 1'b1, 1'b1, 32'h1234, 32'h20}) begin
            errors++;
            $display("FAIL sw_req: req=%b stall=%b we=%b wdata=%h addr=%h, required 1 1 1 00001234 00000020",
                     mem_req, stall, mem_we, mem_wdata, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({MW_valid, MW_wen, MW_RD, MW_data, stall} !== {1'b1, 1'b0, 5'd9, 32'h20, 1'b0}) begin
            errors++;
            $display("FAIL sw_wb: valid=%b wen=%b rd=%0d data=%h stall=%b, required 1 0 9 00000020 0",
                     MW_valid, MW_wen, MW_RD, MW_data, stall);
        end
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({MW_valid, MW_wen, MW_RD, MW_data} !== {1'b1, 1'b1, 5'd6, 32'h55}) begin
            errors++;
            $display("FAIL b2b_add_wb: valid=%b wen=%b rd=%0d data=%h, required 1 1 6 00000055",
                     MW_valid, MW_wen, MW_RD, MW_data);
        end
        @(negedge clk);
        checks++;
        if (MW_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_dup: MW_valid=%b required 0", MW_valid);
        end
    endtask

    task automatic test_rst_wait;
        logic seen_wb;
        resp_en = 1'b0;
        @(posedge clk); #1 drive(1, 1, 0, 3'd2, 5'd7, 32'h44, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        @(negedge clk); @(negedge clk);
        checks++;
        if ({mem_req, stall} !== 2'b11) begin
            errors++; $display("FAIL rst_pre_wait: req=%b stall=%b required 1 1", mem_req, stall);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL rst_async_drop: req=%b stall=%b required 0 0", mem_req, stall);
        end
        @(negedge clk) rst = 1'b0;
        resp_en = 1'b1;
        seen_wb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (MW_valid) seen_wb = 1'b1;
        end
        checks++;
        if (seen_wb !== 1'b0) begin
            errors++; $display("FAIL rst_no_wb: MW_valid seen=%b required 0", seen_wb);
        end
        @(posedge clk); #1 drive(1, 0, 0, 3'd0, 5'd2, 32'h99, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++;
        if ({MW_valid, MW_wen, MW_RD, MW_data} !== {1'b1, 1'b1, 5'd2, 32'h99}) begin
            errors++;
            $display("FAIL rst_resume: valid=%b wen=%b rd=%0d data=%h, required 1 1 2 00000099",
                     MW_valid, MW_wen, MW_RD, MW_data);
        end
    endtask

    task automatic test_timeout;
`ifdef MEM_TIMEOUT_EN
        int n;
        resp_en = 1'b1; ack_lat = 4; rdata_rand = 1'b0; rdata_cfg = 32'hCAFEF00D;
        @(posedge clk); #1 drive(1, 1, 0, 3'd2, 5'd10, 32'h80, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        checks++;
        if ({mem_req, MW_valid, MW_wen, MW_data, mem_err} !== {1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0}) begin
            errors++;
            $display("FAIL ack_at_timeout: req=%b valid=%b wen=%b data=%h err=%b, required 0 1 1 cafef00d 0",
                     mem_req, MW_valid, MW_wen, MW_data, mem_err);
        end
        resp_en = 1'b0;
        @(posedge clk); #1 drive(1, 1, 0, 3'd2, 5'd11, 32'h84, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mem_req) break;
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL timeout_req_cycles: mem_req high %0d cycles, required 4", n);
        end
        checks++;
        if ({stall, MW_valid, MW_wen, mem_err} !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_abort: stall=%b valid=%b wen=%b err=%b, required 0 1 0 1",
                     stall, MW_valid, MW_wen, mem_err);
        end
        @(posedge clk); #1 drive(1, 0, 0, 3'd2, 5'd1, 32'h3, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (mem_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: mem_err=%b required 1", mem_err);
        end
`else
        logic stuck;
        resp_en = 1'b0;
        @(posedge clk); #1 drive(1, 1, 0, 3'd2, 5'd11, 32'h84, 32'h0);
        @(posedge clk); #1 drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        stuck = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!stall || !mem_req || MW_valid || mem_err) stuck = 1'b0;
        end
        checks++;
        if (stuck !== 1'b1) begin
            errors++; $display("FAIL no_timeout_wait: still-waiting=%b required 1", stuck);
        end
`endif
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        resp_en = 1'b1;
        checks++;
        if ({mem_err, stall, mem_req} !== 3'b000) begin
            errors++; $display("FAIL timeout_rst_clear: err=%b stall=%b req=%b required 0 0 0", mem_err, stall, mem_req);
        end
    endtask

    task automatic test_random;
        resp_en = 1'b1; rdata_rand = 1'b1; drv_done = 1'b0;
        rdata_q.delete(); wb_q.delete(); mreq_q.delete();
        fork
            begin
                @(posedge clk); #1;
                for (int k = 0; k < 60; k++) begin
                    int          kind;
                    logic [4:0]  rd;
                    logic [31:0] alu, b;
                    logic [2:0]  cmp;
                    logic        accepted;
                    kind = $urandom_range(0, 4);
                    rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                    alu  = $urandom; b = $urandom;
                    cmp  = (kind == 1) ? 3'd1 : 3'($urandom_range(0, 7));
                    ack_lat = $urandom_range(1, 4);
                    drive(1, kind == 2 || kind == 4, kind >= 3, cmp, rd, alu, b);
                    accepted = 1'b0;
                    for (int c = 0; c < 20 && !accepted; c++) begin
                        @(negedge clk);
                        if (!stall) accepted = 1'b1;
                        @(posedge clk); #1;
                    end
                    if (!accepted) begin
                        checks++; errors++;
                        $display("FAIL rand_accept_timeout: instr %0d not accepted within 20 cycles", k);
                    end else if (kind <= 1) begin
                        wb_q.push_back('{rd, rd != 0 && cmp != 3'd1, alu, 1'b0, 1'b0});
                    end else if (kind == 2) begin
                        wb_q.push_back('{rd, rd != 0, 32'd0, 1'b1, 1'b1});
                        mreq_q.push_back('{alu & 32'hFFFF_FFFC, 1'b0, b});
                    end else begin
                        wb_q.push_back('{rd, 1'b0, alu & 32'hFFFF_FFFC, 1'b1, 1'b0});
                        mreq_q.push_back('{alu & 32'hFFFF_FFFC, 1'b1, b});
                    end
                    drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                drv_done = 1'b1;
            end
            begin
                logic  req_prev;
                logic  done;
                wb_t   e;
                mreq_t m;
                logic [31:0] d;
                req_prev = 1'b0; done = 1'b0;
                for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
                    @(negedge clk);
                    if (mem_req && !req_prev) begin
                        checks++;
                        if (mreq_q.size() == 0) begin
                            errors++; $display("FAIL rand_mreq: unexpected request addr=%h", mem_addr);
                        end else begin
                            m = mreq_q.pop_front();
                            if ({mem_addr, mem_we, mem_wdata} !== {m.addr, m.we, m.wdata}) begin
                                errors++;
                                $display("FAIL rand_mreq: addr=%h we=%b wdata=%h, required %h %b %h",
                                         mem_addr, mem_we, mem_wdata, m.addr, m.we, m.wdata);
                            end
                        end
                    end
                    req_prev = mem_req;
                    if (MW_valid) begin
                        checks++;
                        if (wb_q.size() == 0) begin
                            errors++; $display("FAIL rand_wb: unexpected writeback rd=%0d data=%h", MW_RD, MW_data);
                        end else begin
                            e = wb_q.pop_front();
                            d = e.data;
                            if (e.is_mem) begin
                                if (rdata_q.size() == 0) d = 32'hx;
                                else if (e.is_lw) d = rdata_q.pop_front();
                                else void'(rdata_q.pop_front());
                            end
                            if ({MW_wen, MW_RD, MW_data} !== {e.wen, e.rd, d}) begin
                                errors++;
                                $display("FAIL rand_wb: wen=%b rd=%0d data=%h, required %b %0d %h",
                                         MW_wen, MW_RD, MW_data, e.wen, e.rd, d);
                            end
                        end
                    end
                    if (drv_done && wb_q.size() == 0 && !mem_req && !stall) done = 1'b1;
                end
                checks++;
                if (!done) begin
                    errors++;
                    $display("FAIL rand_drain: %0d writebacks outstanding after cycle budget", wb_q.size());
                end
            end
        join
        rdata_rand = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 3'd2, 5'd0, 32'd0, 32'd0);
        test_reset();
        test_alu();
        test_compare();
        test_lw_wait();
        test_back_to_back();
        test_rst_wait();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
